// File: rtl/arm_controller_if.sv
// Decoder bus: instruction word and NZCV flags in, registered datapath controls out.
interface arm_controller_if;
  logic [31:0] instr;
  logic [3:0]  flags;
  logic        sY;
  logic        sX;
  logic [1:0]  ssrc1Mux;
  logic        regFile_wen;
  logic        DMEM_wen;
  logic        supdate_flags;
  logic [3:0]  sShifter;
  logic [3:0]  sALU;
  logic        sA;
  logic        sB;

  modport master (
    output instr, flags,
    input  sY, sX, ssrc1Mux, regFile_wen, DMEM_wen, supdate_flags,
           sShifter, sALU, sA, sB
  );

  modport slave (
    input  instr, flags,
    output sY, sX, ssrc1Mux, regFile_wen, DMEM_wen, supdate_flags,
           sShifter, sALU, sA, sB
  );
endinterface

// File: rtl/arm_controller.sv
// Registered ARM-subset instruction decoder with one cycle of latency.
// Condition evaluation is enabled by COND_EXEC_EN; otherwise every instruction executes.
module arm_controller (
  input  logic             clk,
  input  logic             reset,
  arm_controller_if.slave  bus
);

  localparam int unsigned MUX_W = 2;
  localparam int unsigned SH_W  = 4;
  localparam int unsigned ALU_W = 4;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0010;

  logic [3:0]       cond;
  logic [1:0]       op;
  logic             i_bit;
  logic [3:0]       cmd;
  logic             s_bit;
  logic             n_f, z_f, c_f, v_f;
  logic             cp;

  logic             nxt_sy;
  logic             nxt_sx;
  logic [MUX_W-1:0] nxt_mux;
  logic             nxt_rw;
  logic             nxt_dw;
  logic             nxt_uf;
  logic [SH_W-1:0]  nxt_sh;
  logic [ALU_W-1:0] nxt_alu;
  logic             nxt_sa;
  logic             nxt_sb;

  assign cond  = bus.instr[31:28];
  assign op    = bus.instr[27:26];
  assign i_bit = bus.instr[25];
  assign cmd   = bus.instr[24:21];
  assign s_bit = bus.instr[20];
  assign {n_f, z_f, c_f, v_f} = bus.flags;

  // Condition-pass evaluation
`ifdef COND_EXEC_EN
  always_comb begin
    cp = 1'b0;
    case (cond)
      4'b0000: cp = z_f;
      4'b0001: cp = !z_f;
      4'b0010: cp = c_f;
      4'b0011: cp = !c_f;
      4'b0100: cp = n_f;
      4'b0101: cp = !n_f;
      4'b0110: cp = v_f;
      4'b0111: cp = !v_f;
      4'b1000: cp = c_f && !z_f;
      4'b1001: cp = !c_f || z_f;
      4'b1010: cp = (n_f == v_f);
      4'b1011: cp = (n_f != v_f);
      4'b1100: cp = !z_f && (n_f == v_f);
      4'b1101: cp = z_f || (n_f != v_f);
      4'b1110: cp = 1'b1;
      default: cp = 1'b0;
    endcase
  end
  logic unused_bits;
  assign unused_bits = ^{bus.instr[19:7], bus.instr[3:0]};
`else
  assign cp = 1'b1;
  logic unused_bits;
  assign unused_bits = ^{bus.instr[19:7], bus.instr[3:0], cond,
                         n_f, z_f, c_f, v_f};
`endif

  // Per-class decode of selects and enables
  always_comb begin
    nxt_sy  = 1'b0;
    nxt_sx  = 1'b0;
    nxt_mux = '0;
    nxt_rw  = 1'b0;
    nxt_dw  = 1'b0;
    nxt_uf  = 1'b0;
    nxt_sh  = '0;
    nxt_alu = '0;
    nxt_sa  = 1'b0;
    nxt_sb  = 1'b0;
    case (op)
      OP_DP: begin
        nxt_alu = cmd;
        nxt_sx  = i_bit;
        if (i_bit) nxt_sh = 4'b1011;
        else       nxt_sh = {1'b0, bus.instr[4], bus.instr[6:5]};
        // TST/TEQ/CMP/CMN always update flags and never write back
        if (cmd[3:2] == 2'b10) begin
          nxt_uf = cp;
        end else begin
          nxt_rw = cp;
          nxt_uf = cp & s_bit;
        end
      end
      OP_MEM: begin
        nxt_alu = bus.instr[23] ? ALU_ADD : ALU_SUB;
        if (!i_bit) nxt_sb = 1'b1;
        else        nxt_sh = {2'b00, bus.instr[6:5]};
        if (bus.instr[20]) begin
          nxt_rw  = cp;
          nxt_mux = 2'b01;
        end else begin
          nxt_dw = cp;
          nxt_sy = 1'b1;
        end
      end
      OP_BR: begin
        nxt_sa  = 1'b1;
        nxt_sb  = 1'b1;
        nxt_alu = ALU_ADD;
        nxt_rw  = cp & bus.instr[24];
        nxt_mux = 2'b11;
      end
      default: begin
        nxt_mux = 2'b10;
        nxt_alu = ALU_ADD;
        nxt_rw  = cp;
        nxt_uf  = cp & s_bit;
      end
    endcase
  end

  // Output registers, reset has priority over decode
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.sY            <= 1'b0;
      bus.sX            <= 1'b0;
      bus.ssrc1Mux      <= '0;
      bus.regFile_wen   <= 1'b0;
      bus.DMEM_wen      <= 1'b0;
      bus.supdate_flags <= 1'b0;
      bus.sShifter      <= '0;
      bus.sALU          <= '0;
      bus.sA            <= 1'b0;
      bus.sB            <= 1'b0;
    end else begin
      bus.sY            <= nxt_sy;
      bus.sX            <= nxt_sx;
      bus.ssrc1Mux      <= nxt_mux;
      bus.regFile_wen   <= nxt_rw;
      bus.DMEM_wen      <= nxt_dw;
      bus.supdate_flags <= nxt_uf;
      bus.sShifter      <= nxt_sh;
      bus.sALU          <= nxt_alu;
      bus.sA            <= nxt_sa;
      bus.sB            <= nxt_sb;
    end
  end

endmodule

// File: tb/tb_arm_controller.sv
// Self-checking bench for arm_controller: directed test-plan steps then random
// instructions against a behavioural decode model (honours COND_EXEC_EN).
module tb_arm_controller;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  arm_controller_if bus ();

  arm_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Output bundle: {sY,sX,ssrc1Mux,regFile_wen,DMEM_wen,supdate_flags,sShifter,sALU,sA,sB}
  function automatic logic [16:0] pack(input logic y, x, input logic [1:0] m,
                                       input logic rw, dw, uf,
                                       input logic [3:0] sh, alu,
                                       input logic a, b);
    return {y, x, m, rw, dw, uf, sh, alu, a, b};
  endfunction

  function automatic logic [16:0] observed();
    return pack(bus.sY, bus.sX, bus.ssrc1Mux, bus.regFile_wen, bus.DMEM_wen,
                bus.supdate_flags, bus.sShifter, bus.sALU, bus.sA, bus.sB);
  endfunction

  // Reference: condition truth table indexed by cond, then per-class rules
  function automatic bit passes(input logic [3:0] cond, input logic [3:0] f);
`ifdef COND_EXEC_EN
    bit n, z, c, v;
    bit [15:0] tbl;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    tbl = {1'b0, 1'b1, z | (n ^ v), !z & !(n ^ v), n ^ v, !(n ^ v),
           !c | z, c & !z, !v, v, !n, n, !c, c, !z, z};
    return tbl[cond];
`else
    return (cond === cond) && (f === f);
`endif
  endfunction

  function automatic logic [16:0] model(input logic [31:0] ins, input logic [3:0] f);
    bit p;
    int cls;
    logic [3:0] c;
    p   = passes(ins[31:28], f);
    cls = int'(ins[27:26]);
    c   = ins[24:21];
    if (cls == 0) begin
      logic [3:0] sh;
      bit is_cmp;
      sh = ins[25] ? 4'hB : (ins[4] ? {2'b01, ins[6:5]} : {2'b00, ins[6:5]});
      is_cmp = (c >= 4'd8) && (c <= 4'd11);
      return pack(0, ins[25], 2'd0, p && !is_cmp, 0, p && (is_cmp || ins[20]),
                  sh, c, 0, 0);
    end else if (cls == 1) begin
      bit ld;
      ld = ins[20];
      return pack(!ld, 0, ld ? 2'd1 : 2'd0, p && ld, p && !ld, 0,
                  ins[25] ? {2'b00, ins[6:5]} : 4'd0,
                  ins[23] ? 4'd4 : 4'd2, 0, !ins[25]);
    end else if (cls == 2) begin
      return pack(0, 0, 2'd3, p && ins[24], 0, 0, 4'd0, 4'd4, 1, 1);
    end
    return pack(0, 0, 2'd2, p, 0, p && ins[20], 4'd0, 4'd4, 0, 0);
  endfunction

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] ins, input logic [3:0] f);
    reset     = r;
    bus.instr = ins;
    bus.flags = f;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input logic [3:0] f);
    drive(1'b0, ins, f);
    chk(tag, observed(), model(ins, f));
  endtask

  bit cp_on;

  initial begin
`ifdef COND_EXEC_EN
    cp_on = 1'b1;
`else
    cp_on = 1'b0;
`endif
    reset = 1'b1; bus.instr = 32'hE011_2003; bus.flags = 4'h0;
    @(posedge clk); #1;
    chk("reset_all_zero", observed(), 17'd0);

    step("and_s", 32'hE011_2003, 4'h0);
    chk("and_s_const", observed(), pack(0, 0, 2'd0, 1, 0, 1, 4'h0, 4'h0, 0, 0));

    step("add_lsl_reg", 32'hE081_0312, 4'h0);
    chk("add_fields", 17'({bus.sALU, bus.sShifter, bus.regFile_wen, bus.supdate_flags}),
        17'({4'b0100, 4'b0100, 1'b1, 1'b0}));

    step("mul_s", 32'hEC11_0002, 4'h0);
    chk("mul_fields", 17'({bus.ssrc1Mux, bus.regFile_wen, bus.supdate_flags, bus.sShifter, bus.DMEM_wen}),
        17'({2'b10, 1'b1, 1'b1, 4'b0000, 1'b0}));

    step("andeq_fail", 32'h0011_2003, 4'h0);
    chk("andeq_fail_fields", 17'({bus.regFile_wen, bus.supdate_flags, bus.sALU}),
        17'({!cp_on, !cp_on, 4'b0000}));
    step("andeq_pass", 32'h0011_2003, 4'h4);
    chk("andeq_pass_fields", 17'({bus.regFile_wen, bus.supdate_flags}), 17'(2'b11));

    step("str", 32'hE581_2004, 4'h0);
    chk("str_fields", 17'({bus.DMEM_wen, bus.regFile_wen, bus.sB, bus.sY, bus.sALU}),
        17'({1'b1, 1'b0, 1'b1, 1'b1, 4'b0100}));
    step("ldr", 32'hE591_2004, 4'h0);
    chk("ldr_fields", 17'({bus.regFile_wen, bus.ssrc1Mux, bus.DMEM_wen}),
        17'({1'b1, 2'b01, 1'b0}));

    step("cmp", 32'hE151_0002, 4'h0);
    chk("cmp_fields", 17'({bus.regFile_wen, bus.supdate_flags, bus.sALU}),
        17'({1'b0, 1'b1, 4'b1010}));
    // Mid-cycle input change must not reach the outputs before the edge
    bus.instr = 32'hE581_2004;
    #3;
    chk("latency_hold", observed(), model(32'hE151_0002, 4'h0));
    @(posedge clk); #1;
    chk("latency_update", observed(), model(32'hE581_2004, 4'h0));

    step("never_cond", 32'hF081_0312, 4'hF);
    step("branch_link", 32'hEB00_0010, 4'h0);
    drive(1'b1, 32'hEC11_0002, 4'hF);
    chk("reset_priority", observed(), 17'd0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      logic [3:0]  f;
      logic        r;
      ins = $urandom;
      f   = 4'($urandom_range(0, 15));
      r   = ($urandom_range(0, 15) == 0);
      drive(r, ins, f);
      chk($sformatf("rand%0d_%h_%h_r%0d", i, ins, f, r), observed(),
          r ? 17'd0 : model(ins, f));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arm_controller.md
Name: arm_controller

Overview:
- Registered instruction decoder for the single-cycle ARM-subset datapath.
- Takes the 32-bit instruction word and the NZCV flags and evaluates the condition code.
- Drives the datapath mux selects, the shifter and ALU op codes, and the register-file / data-memory / flag write enables.
- Sits between instruction memory and the datapath.

Parameters:
- none

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- instr  in  32  instruction: cond[31:28] op[27:26] I[25] cmd[24:21] S[20] Rn[19:16] Rd[15:12] op2[11:0]
- flags  in  4  {N,Z,C,V}
- sY  out  1  reg-file read port 2 address: 0=Rm instr[3:0], 1=Rd instr[15:12] (store data)
- sX  out  1  shifter input: 0=register Rm, 1=rotated imm8
- ssrc1Mux  out  2  reg-file write data: 00=ALU, 01=DMEM read data, 10=multiplier, 11=PC+4
- regFile_wen  out  1  register-file write enable
- DMEM_wen  out  1  data-memory write enable
- supdate_flags  out  1  flag-register update enable
- sShifter  out  4  {imm_rot, shift_by_reg, type[1:0]}
- sALU  out  4  ALU op, ARM cmd encoding
- sA  out  1  ALU A: 0=Rn, 1=PC
- sB  out  1  ALU B: 0=shifter output, 1=extended immediate (imm12 / imm24)

Behaviour:
- Decode is combinational from instr/flags; all outputs are registered. One-cycle latency: outputs reflect instr/flags sampled at the previous rising edge.
- Reset: on a clk edge with reset=1, all outputs become 0. Reset has priority over decode.
- Condition pass (cp):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL(1110)=1; 1111 = never.
  - If cp=0: regFile_wen, DMEM_wen and supdate_flags are 0. All selects still decode normally.
- op=00, data processing:
  - sALU=cmd.
  - sX=I, sB=0, sA=0, sY=0, ssrc1Mux=00, DMEM_wen=0.
  - sShifter:
    - I=1: 1011 (rotate-right imm8 by 2*rot).
    - I=0, instr[4]=1: {0,1,instr[6:5]} (shift amount from Rs instr[11:8]).
    - otherwise: {0,0,instr[6:5]} (shamt5).
  - Compare ops TST/TEQ/CMP/CMN (10xx): regFile_wen=0, supdate_flags=cp regardless of S.
  - Other ops: regFile_wen=cp, supdate_flags=cp&S.
- op=01, load/store (L=instr[20], U=instr[23]):
  - sALU=0100 if U else 0010. sA=0, supdate_flags=0.
  - I=0: sB=1 (imm12, zero-extended). I=1: sB=0, sX=0, sShifter={0,0,instr[6:5]}.
  - L=1: regFile_wen=cp, ssrc1Mux=01, DMEM_wen=0, sY=0.
  - L=0: DMEM_wen=cp, regFile_wen=0, sY=1.
- op=10, branch:
  - sA=1, sB=1 (sign-extended imm24<<2), sALU=0100.
  - regFile_wen=cp&instr[24] (link), ssrc1Mux=11. DMEM_wen=0, supdate_flags=0.
- op=11, multiply:
  - Rd = Rn*Rm. ssrc1Mux=10, sY=0, sX=0, sShifter=0000, sALU=0100, sA=0, sB=0.
  - regFile_wen=cp, supdate_flags=cp&S, DMEM_wen=0.
- Unused select bits per class are 0 except where listed above.

Optional Feature:
- Macro COND_EXEC_EN.
  - Defined: condition evaluation as above.
  - Undefined: cp is forced to 1 (every instruction treated as AL); flags input is ignored.

Test Plan:
- Reset: reset=1 for one edge -> all outputs 0. Deassert with instr=0xE0112003 (AND r2,r1,r3, S=1), flags=0000 -> after next edge: sALU=0000, sShifter=0000, regFile_wen=1, supdate_flags=1, DMEM_wen=0, ssrc1Mux=00, sX=0, sA=0, sB=0, sY=0.
- instr=0xE0810312 (ADD r0,r1,r2,LSL r3) -> sALU=0100, sShifter=0100, regFile_wen=1, supdate_flags=0.
- instr=0xEC110002 (MUL r0,r1,r2, S=1) -> ssrc1Mux=10, regFile_wen=1, supdate_flags=1, sShifter=0000, DMEM_wen=0.
- Conditional: instr=0x00112003 (ANDEQ), flags=0000 -> regFile_wen=0, supdate_flags=0, sALU=0000. Same instr with flags=0100 -> regFile_wen=1, supdate_flags=1.
- Store/load:
  - instr=0xE5812004 (STR) -> DMEM_wen=1, regFile_wen=0, sB=1, sY=1, sALU=0100.
  - instr=0xE5912004 (LDR) -> regFile_wen=1, ssrc1Mux=01, DMEM_wen=0.
- Compare and latency: instr=0xE1510002 (CMP, S=1) -> regFile_wen=0, supdate_flags=1, sALU=1010. Changing instr mid-cycle does not affect outputs until the next edge.
